// File: rtl/fetch_sequencer.sv
// Dual-port ROM fetch sequencer: issues word-pair reads, buffers returns in a 4-entry pair FIFO.
// Optional stall cycle counter is enabled by defining FETCH_SEQ_STALL_CNT_EN.
module fetch_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] length,
   output logic [ADDR_W-1:0] address_a,
   output logic [ADDR_W-1:0] address_b,
   input  logic [DATA_W-1:0] rom_q_a,
   input  logic [DATA_W-1:0] rom_q_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data_a,
   output logic [DATA_W-1:0] out_data_b,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef FETCH_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]       stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] length_q, length_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [RD_LAT-1:0] pend_q, pend_d;
   logic [RD_LAT-1:0] tag_q, tag_d;
   logic [DATA_W-1:0] fifo_a_q [4];
   logic [DATA_W-1:0] fifo_a_d [4];
   logic [DATA_W-1:0] fifo_b_q [4];
   logic [DATA_W-1:0] fifo_b_d [4];
   logic [3:0]        fifo_l_q, fifo_l_d;
   logic [1:0]        head_q, head_d;
   logic [1:0]        tail_q, tail_d;
   logic [2:0]        count_q, count_d;
   logic              done_q, done_d;

   logic [2:0]        in_flight;
   logic              issue;
   logic              issue_last;
   logic              push;
   logic              pop;

   // pend_q is a shift register of outstanding reads; its tail marks data arriving this cycle
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + 3'(pend_q[i]);
      end
   end

   assign address_a  = base_q + {k_q[ADDR_W-2:0], 1'b0};
   assign address_b  = address_a + ADDR_W'(1);
   assign issue      = (state_q == FETCH) && (({1'b0, in_flight} + {1'b0, count_q}) < 4'd4);
   assign issue_last = issue && (k_q == length_q - ADDR_W'(1));
   assign push       = pend_q[RD_LAT-1];
   assign out_valid  = (count_q != 3'd0);
   assign pop        = out_valid && out_ready;
   assign out_data_a = out_valid ? fifo_a_q[head_q] : '0;
   assign out_data_b = out_valid ? fifo_b_q[head_q] : '0;
   assign out_last   = out_valid && fifo_l_q[head_q];
   assign busy       = (state_q == FETCH) || (state_q == DRAIN);
   assign done       = done_q;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      length_d = length_q;
      k_d      = k_q;
      fifo_a_d = fifo_a_q;
      fifo_b_d = fifo_b_q;
      fifo_l_d = fifo_l_q;
      head_d   = head_q;
      tail_d   = tail_q;
      done_d   = (state_q == FINISH);

      pend_d[0] = issue;
      tag_d[0]  = issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
         pend_d[i] = pend_q[i-1];
         tag_d[i]  = tag_q[i-1];
      end

      if (push) begin
         fifo_a_d[tail_q] = rom_q_a;
         fifo_b_d[tail_q] = rom_q_b;
         fifo_l_d[tail_q] = tag_q[RD_LAT-1];
         tail_d           = tail_q + 2'd1;
      end
      if (pop) begin
         head_d = head_q + 2'd1;
      end
      count_d = count_q + 3'(push) - 3'(pop);

      if (issue) begin
         k_d = k_q + ADDR_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d   = base;
               length_d = length;
               k_d      = '0;
               state_d  = (length == '0) ? FINISH : FETCH;
            end
         end
         FETCH:   if (issue_last) state_d = DRAIN;
         DRAIN:   if (pop && out_last) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         length_q <= '0;
         k_q      <= '0;
         pend_q   <= '0;
         tag_q    <= '0;
         fifo_l_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         length_q <= length_d;
         k_q      <= k_d;
         pend_q   <= pend_d;
         tag_q    <= tag_d;
         fifo_l_q <= fifo_l_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   // Payload storage needs no reset: outputs are gated by out_valid
   always_ff @(posedge clock) begin
      fifo_a_q <= fifo_a_d;
      fifo_b_q <= fifo_b_d;
   end

`ifdef FETCH_SEQ_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule
